// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Moves one load or store at a time between the register file and a
//   single-port data RAM. The RAM has a registered read port, so a load
//   needs one issue cycle and one read cycle before its data can be
//   captured. The captured result is then held until the register file
//   accepts it.
//
// Optional feature (compile-time macro):
//   LSU_RANGE_CHECK_EN
//     defined   : a request with a non-zero op2[15:10] sets the sticky
//                 range_fault flag. A store with such an address does not
//                 write, and a load with such an address returns 0x0000 with
//                 the normal timing.
//     undefined : op2[15:10] is ignored, so the address is truncated to
//                 10 bits. range_fault is tied to 0.
//
// Ports:
//   clk              in   1   single clock, all state updates on posedge
//   rst              in   1   synchronous active-high reset
//   req_valid        in   1   a load/store request is present
//   req_ready        out  1   the unit is idle and can accept a request
//   req_is_store     in   1   1 = store, 0 = load
//   op1              in  16   store data
//   op2              in  16   word address (low 10 bits reach the RAM)
//   req_rd           in   3   destination register of a load
//   mem_addr         out 10   RAM address
//   mem_write_data   out 16   RAM write data
//   mem_write_enable out  1   RAM write strobe
//   mem_read_data    in  16   RAM read data, valid one cycle after address
//   resp_valid       out  1   load result available
//   resp_ready       in   1   register file accepts the load result
//   resp_data        out 16   load result
//   resp_rd          out  3   destination register of the load result
//   range_fault      out  1   sticky out-of-range flag
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic [2:0]  req_rd,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [15:0] mem_read_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [2:0]  resp_rd,
  output logic        range_fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [9:0]  r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_is_store;
  logic [2:0]  r_rd;
  logic        r_oor;
  logic [15:0] r_resp_data;
  logic [2:0]  r_resp_rd;
  logic        w_accept;
  logic        w_oor;

  assign w_accept = req_valid & (r_state == S_IDLE);

`ifdef LSU_RANGE_CHECK_EN
  logic r_range_fault;

  assign w_oor = (op2[15:10] != 6'd0);

  // Sticky fault flag: set by any accepted out-of-range request, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_range_fault <= 1'b0;
    end else if (w_accept & w_oor) begin
      r_range_fault <= 1'b1;
    end
  end

  assign range_fault = r_range_fault;
`else
  // The upper address bits have no function without the range check.
  logic w_unused_addr_hi;

  assign w_unused_addr_hi = |op2[15:10];
  assign w_oor            = 1'b0;
  assign range_fault      = 1'b0;
`endif

  // Next-state logic: stores finish after ISSUE, loads pass through READ into RESP
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_is_store) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, request capture and load-result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= 10'd0;
      r_mem_wdata <= 16'd0;
      r_is_store  <= 1'b0;
      r_rd        <= 3'd0;
      r_oor       <= 1'b0;
      r_resp_data <= 16'd0;
      r_resp_rd   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      // The address and data are captured only on accept, so they hold
      // their last values in every other cycle.
      if (w_accept) begin
        r_mem_addr  <= op2[9:0];
        r_mem_wdata <= op1;
        r_is_store  <= req_is_store;
        r_rd        <= req_rd;
        r_oor       <= w_oor;
      end
      // The RAM read data is valid during READ because the address was
      // presented to the RAM at the edge that ended ISSUE.
      if (r_state == S_READ) begin
        r_resp_data <= r_oor ? 16'd0 : mem_read_data;
        r_resp_rd   <= r_rd;
      end
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = (r_state == S_RESP);
  assign resp_data      = r_resp_data;
  assign resp_rd        = r_resp_rd;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  // The strobe is gated by rst directly so that a reset arriving during
  // ISSUE blocks the write on that same edge.
  assign mem_write_enable = (r_state == S_ISSUE) & r_is_store & ~r_oor & ~rst;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  single clock, shared with the register file and the data RAM; all state updates on posedge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  a load/store request is present.
REQ-005 req_ready  output  1  the block can accept a request.
REQ-006 req_is_store  input  1  1 = store, 0 = load.
REQ-007 op1  input  16  store data.
REQ-008 op2  input  16  byte-free word address.
REQ-009 req_rd  input  3  destination register index for a load.
REQ-010 mem_addr  output  10  address to the RAM.
REQ-011 mem_write_data  output  16  write data to the RAM.
REQ-012 mem_write_enable  output  1  RAM write strobe.
REQ-013 mem_read_data  input  16  RAM read data, registered in the RAM, valid one cycle after the address edge.
REQ-014 resp_valid  output  1  load result is available.
REQ-015 resp_ready  input  1  the register file accepts the load result.
REQ-016 resp_data  output  16  load result.
REQ-017 resp_rd  output  3  destination register index of the load result.
REQ-018 range_fault  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, READ and RESP.
REQ-020 req_ready SHALL equal (state==IDLE); a request is accepted on a posedge where req_valid and req_ready are both 1.
REQ-021 On accept, the block SHALL register mem_addr=op2[9:0], mem_write_data=op1, is_store and rd, and move to ISSUE.
REQ-022 In ISSUE, mem_write_enable SHALL be is_store & ~rst; it SHALL be 0 in every other state.
REQ-023 A store in ISSUE SHALL return to IDLE on the next edge, so req_ready is high again one cycle after the accept edge; stores SHALL produce no response.
REQ-024 A load SHALL go ISSUE->READ, then capture resp_data=mem_read_data at the end of READ and enter RESP; resp_valid SHALL therefore rise 2 cycles after the accept edge.
REQ-025 In RESP, resp_valid=1 and resp_data/resp_rd SHALL be held stable until the posedge on which resp_ready=1, which returns the FSM to IDLE.
REQ-026 resp_valid SHALL be 1 only in RESP; no new request is accepted while a response is pending.
REQ-027 mem_addr and mem_write_data SHALL hold their last values outside ISSUE/READ.

Reset
REQ-028 On a posedge with rst=1, the block SHALL set state=IDLE, resp_valid=0, resp_data=0, resp_rd=0, mem_addr=0, mem_write_data=0 and range_fault=0; with state IDLE, req_ready reads 1 after that edge.
REQ-029 rst asserted during ISSUE of a store SHALL suppress the write; mem_write_enable is gated by ~rst.
REQ-030 rst asserted in READ or RESP SHALL discard the pending load with no response.

Configuration
REQ-031 Macro LSU_RANGE_CHECK_EN defined: an accepted request with op2[15:10]!=0 SHALL set range_fault (sticky until reset), keep mem_write_enable at 0 for a store, and give a load resp_data=0x0000 with normal timing.
REQ-032 Macro LSU_RANGE_CHECK_EN undefined: op2[15:10] SHALL be ignored (the address is truncated) and range_fault SHALL be tied to 0.

Verification
REQ-033 The bench SHALL pair the block with the team RAM, initial content word i = i.
REQ-034 Load with op2=0x0005, rd=3, resp_ready=1 -> resp_valid rises 2 cycles after accept, resp_data=0x0005, resp_rd=3, req_ready low for 3 cycles.
REQ-035 Store op1=0xBEEF, op2=0x0010, then load 0x0010 -> the write strobe is high exactly 1 cycle and the load returns 0xBEEF.
REQ-036 Load 0x03FF with resp_ready held 0 for 5 cycles -> resp_valid and resp_data=0x03FF are stable for 5 cycles, there is no second accept, and the FSM returns to IDLE on the resp_ready edge.
REQ-037 Store to 0x0020 with rst asserted in ISSUE -> no RAM write (a later load of 0x0020 returns 0x0020) and all outputs are at reset values.
REQ-038 Load op2=0x0405: with LSU_RANGE_CHECK_EN -> resp_data=0x0000 and range_fault=1; without it -> resp_data=0x0005 and range_fault=0.
